// File: rtl/mem_seq.sv
// Sequences one host load/store of 1..8 bytes onto a byte-wide synchronous RAM, one byte per cycle.
// A store completes N+1 cycles after acceptance and a load N+2; req is ignored while busy (no queuing).
module mem_seq #(
    parameter int DW = 64,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int NB = DW / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    n_q, n_d;
    logic          sext_q, sext_d;
    logic          err_q, err_d;
    logic [DW-1:0] wsh_q, wsh_d;
    logic [DW-1:0] rbuf_q, rbuf_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic [3:0]    req_n;
    int            cap_i;
    int            n_i;
    logic          sign;
    logic [DW-1:0] cap_buf;
    logic [DW-1:0] ext_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= 4'd1;
            sext_q      <= 1'b0;
            err_q       <= 1'b0;
            wsh_q       <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            sext_q      <= sext_d;
            err_q       <= err_d;
            wsh_q       <= wsh_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // cnt_q is the index of the byte whose address is on mem_addr; the RAM
    // answers one cycle later, so the slot being captured is always cnt_q-1.
    always_comb begin
        req_n = 4'd1 << size;
        cap_i = int'(cnt_q) - 1;
        n_i   = int'(n_q);

        cap_buf = rbuf_q;
        for (int i = 0; i < NB; i++) begin
            if (i == cap_i) begin
                cap_buf[8*i +: 8] = mem_rdata;
            end
        end

        sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == n_i - 1) begin
                sign = cap_buf[8*i+7];
            end
        end

        ext_buf = '0;
        for (int i = 0; i < NB; i++) begin
            ext_buf[8*i +: 8] = (i < n_i) ? cap_buf[8*i +: 8] : {8{sign & sext_q}};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        sext_d      = sext_q;
        err_d       = err_q;
        wsh_d       = wsh_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    n_d    = req_n;
                    sext_d = sext;
                    cnt_d  = '0;
                    rbuf_d = '0;
                    if (int'(req_n) > NB) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        err_d      = 1'b0;
                        mem_addr_d = addr;
                        if (we) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata[7:0];
                            wsh_d       = wdata >> 8;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            WR: begin
                if (cnt_q == n_q - 4'd1) begin
                    state_d = FIN;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    mem_wdata_d = wsh_q[7:0];
                    wsh_d       = wsh_q >> 8;
                end
            end
            RD: begin
                rbuf_d = cap_buf;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == n_q - 4'd1) begin
                    state_d = DRAIN;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                rbuf_d  = cap_buf;
                rdata_d = ext_buf;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = (state_q == FIN) && err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: 64-bit instance against a byte-array memory model, plus a 32-bit instance for rejection.
module tb_mem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [15:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        busy, done, err, mem_we;
    logic [63:0] rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        req32 = 1'b0, we32 = 1'b0, sext32 = 1'b0;
    logic [1:0]  size32 = 2'd0;
    logic [7:0]  addr32 = '0;
    logic [31:0] wdata32 = '0;
    logic        busy32, done32, err32, mem_we32;
    logic [31:0] rdata32;
    logic [7:0]  mem_addr32;
    logic [7:0]  mem_wdata32, mem_rdata32;

    bit [7:0]    ram   [65536];
    bit [7:0]    mram  [65536];
    bit [7:0]    ram32 [256];
    int          nwr = 0, nwr32 = 0;
    int          n_checks = 0, n_fail = 0;
    logic [63:0] exp_rdata = '0;

    mem_seq #(.DW(64), .AW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_seq #(.DW(32), .AW(8)) dut32 (
        .clk(clk), .rst(rst), .req(req32), .we(we32), .size(size32), .sext(sext32),
        .addr(addr32), .wdata(wdata32), .busy(busy32), .done(done32), .err(err32),
        .rdata(rdata32), .mem_addr(mem_addr32), .mem_we(mem_we32),
        .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            nwr <= nwr + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we32) begin
            ram32[mem_addr32] <= mem_wdata32;
            nwr32 <= nwr32 + 1;
        end
        mem_rdata32 <= ram32[mem_addr32];
    end

    // One complete access on the 64-bit instance, checked cycle by cycle against the byte-array model.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [15:0] a, input logic [63:0] wd);
        int nb, j, exp_lat;
        logic [63:0] v;
        nb = 1 << sz;
        exp_lat = w ? nb + 1 : nb + 2;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk);
        j = 0;
        while (j < 20) begin
            @(negedge clk);
            j++;
            req = 1'b0;
            we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
            addr = 16'($urandom); wdata = {$urandom, $urandom};
            if (done) break;
            if (j <= nb) begin
                n_checks++;
                if (mem_we !== w || mem_addr !== 16'(a + j - 1) || busy !== 1'b1 ||
                    (w && mem_wdata !== wd[8*(j-1) +: 8])) begin
                    n_fail++;
                    $display("FAIL op_cycle%0d: we=%b addr=%h wdat=%h busy=%b, required we=%b addr=%h wdat=%h busy=1",
                             j, mem_we, mem_addr, mem_wdata, busy, w, 16'(a + j - 1), wd[8*(j-1) +: 8]);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || j != exp_lat) begin
            n_fail++;
            $display("FAIL op_latency: done=%b after %0d cycles, required done after %0d", done, j, exp_lat);
        end
        if (w) begin
            for (int k = 0; k < nb; k++) mram[16'(a + k)] = wd[8*k +: 8];
        end else begin
            v = '0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = mram[16'(a + k)];
            if (sx && nb < 8 && v[8*nb-1]) v = v | ({64{1'b1}} << (8*nb));
            exp_rdata = v;
        end
        n_checks++;
        if (err !== 1'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL op_result: err=%b rdata=%h, required err=0 rdata=%h", err, rdata, exp_rdata);
        end
    endtask

    task automatic run32(input logic w, input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] wd, output int lat, output bit saw_we, output bit saw_err);
        @(negedge clk);
        req32 = 1'b1; we32 = w; size32 = sz; sext32 = 1'b0; addr32 = a; wdata32 = wd;
        @(posedge clk);
        lat = 0; saw_we = 1'b0; saw_err = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            req32 = 1'b0;
            if (mem_we32) saw_we = 1'b1;
            if (done32) begin
                saw_err = err32;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 1'b1; req32 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, mem_we} !== 4'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b err=%b we=%b addr=%h wdat=%h, required all 0",
                     busy, done, err, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if (rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 0", rdata);
        end
        n_checks++;
        if ({busy32, done32, err32, mem_we32} !== 4'b0 || rdata32 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut32: busy=%b done=%b err=%b we=%b rdata=%h, required all 0",
                     busy32, done32, err32, mem_we32, rdata32);
        end
        req = 1'b0; req32 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b busy32=%b, required 0 0", busy, busy32);
        end
    endtask

    task automatic test_store();
        run_op(1'b1, 2'd2, 1'b1, 16'h0010, 64'h0123_4567_A1B2_C3D4);
        n_checks++;
        if ({ram[16'h10], ram[16'h11], ram[16'h12], ram[16'h13]} !== 32'hD4C3_B2A1 || ram[16'h14] !== 8'h00) begin
            n_fail++;
            $display("FAIL store_bytes: got %h %h %h %h %h, required d4 c3 b2 a1 00",
                     ram[16'h10], ram[16'h11], ram[16'h12], ram[16'h13], ram[16'h14]);
        end
    endtask

    task automatic test_load_sext();
        run_op(1'b1, 2'd1, 1'b0, 16'h0020, 64'h0000_0000_0000_8534);
        run_op(1'b0, 2'd1, 1'b1, 16'h0020, 64'h0);
        n_checks++;
        if (rdata !== 64'hFFFF_FFFF_FFFF_8534) begin
            n_fail++;
            $display("FAIL load_sext1: got %h, required ffffffffffff8534", rdata);
        end
        run_op(1'b0, 2'd1, 1'b0, 16'h0020, 64'h0);
        n_checks++;
        if (rdata !== 64'h0000_0000_0000_8534) begin
            n_fail++;
            $display("FAIL load_sext0: got %h, required 0000000000008534", rdata);
        end
    endtask

    task automatic test_wrap();
        run_op(1'b1, 2'd2, 1'b0, 16'hFFFE, 64'h0000_0000_DDCC_BBAA);
        n_checks++;
        if ({ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000], ram[16'h0001]} !== 32'hAABB_CCDD) begin
            n_fail++;
            $display("FAIL wrap_store: got %h %h %h %h, required aa bb cc dd",
                     ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000], ram[16'h0001]);
        end
        run_op(1'b0, 2'd2, 1'b1, 16'hFFFE, 64'h0);
        n_checks++;
        if (rdata !== 64'hFFFF_FFFF_DDCC_BBAA) begin
            n_fail++;
            $display("FAIL wrap_load: got %h, required ffffffffddccbbaa", rdata);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                            : 16'h0100 + 16'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(1'(i % 2 == 0), 2'(i % 4), 1'b1, 16'h0300 + 16'(i), {$urandom, $urandom});
        end
    endtask

    task automatic test_reject();
        int lat, base;
        bit sw, se;
        run32(1'b1, 2'd2, 8'h10, 32'hCAFE_BABE, lat, sw, se);
        n_checks++;
        if (lat != 5 || sw !== 1'b1 || se !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_store32: lat=%0d we_seen=%b err=%b, required 5 1 0", lat, sw, se);
        end
        run32(1'b0, 2'd2, 8'h10, 32'h0, lat, sw, se);
        n_checks++;
        if (lat != 6 || rdata32 !== 32'hCAFE_BABE) begin
            n_fail++;
            $display("FAIL rej_load32: lat=%0d rdata=%h, required 6 cafebabe", lat, rdata32);
        end
        for (int i = 0; i < 2; i++) begin
            base = nwr32;
            run32(1'(i), 2'd3, 8'h40, 32'h1234_5678, lat, sw, se);
            n_checks++;
            if (lat != 1 || se !== 1'b1 || sw !== 1'b0 || nwr32 != base || rdata32 !== 32'hCAFE_BABE) begin
                n_fail++;
                $display("FAIL reject%0d: lat=%0d err=%b we_seen=%b writes=%0d rdata=%h, required 1 1 0 0 cafebabe",
                         i, lat, se, sw, nwr32 - base, rdata32);
            end
        end
    endtask

    task automatic test_busy_abort();
        int base;
        bit saw_done;
        logic [15:0] a;
        logic [63:0] wd;
        a = 16'h0500;
        wd = 64'h8877_6655_4433_2211;
        run_op(1'b0, 2'd0, 1'b0, 16'h0020, 64'h0);
        base = nwr;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd3; sext = 1'b0; addr = a; wdata = wd;
        @(posedge clk);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            req = (j == 1); we = 1'b0; addr = 16'h1234;
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== a + 16'(j - 1) || mem_wdata !== wd[8*(j-1) +: 8] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_cycle%0d: we=%b addr=%h wdat=%h done=%b, required 1 %h %h 0",
                         j, mem_we, mem_addr, mem_wdata, done, a + 16'(j - 1), wd[8*(j-1) +: 8]);
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: we=%b busy=%b done=%b, required 0 0 0", mem_we, busy, done);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        for (int k = 0; k < 3; k++) mram[a + 16'(k)] = wd[8*k +: 8];
        exp_rdata = '0;
        n_checks++;
        if (nwr - base != 3 || saw_done || rdata !== 64'h0 || ram[a + 16'd3] !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_result: writes=%0d done_seen=%b rdata=%h byte3=%h, required 3 0 0 00",
                     nwr - base, saw_done, rdata, ram[a + 16'd3]);
        end
        rst = 1'b0;
        run_op(1'b0, 2'd3, 1'b0, a, 64'h0);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_sext();
        test_wrap();
        test_reject();
        test_random();
        test_back_to_back();
        test_busy_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter DW, default 64: host data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter AW, default 16: byte address width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: access request, sampled only while busy=0.
REQ-006 SHALL have port we, input, 1: 1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port size, input, 2: log2 of the byte count N (0→1, 1→2, 2→4, 3→8 bytes).
REQ-008 SHALL have port sext, input, 1: for loads, 1 = sign-extend and 0 = zero-extend the result to DW.
REQ-009 SHALL have port addr, input, AW: base byte address.
REQ-010 SHALL have port wdata, input, DW: store data; bytes 0..N-1 are used.
REQ-011 SHALL have port busy, output, 1: high from the cycle after acceptance until the done cycle inclusive.
REQ-012 SHALL have port done, output, 1: single-cycle pulse marking completion.
REQ-013 SHALL have port err, output, 1: pulses with done when the request was rejected.
REQ-014 SHALL have port rdata, output, DW: the last completed load result.
REQ-015 SHALL have port mem_addr, output, AW: byte RAM address.
REQ-016 SHALL have port mem_we, output, 1: byte RAM write enable.
REQ-017 SHALL have port mem_wdata, output, 8: byte RAM write data.
REQ-018 SHALL have port mem_rdata, input, 8: byte RAM read data; synchronous, valid one cycle after mem_addr is presented.

Function
REQ-019 SHALL implement states IDLE, WR, RD, DRAIN and FIN.
REQ-020 SHALL, in IDLE with req=1, latch we, size, sext, addr and wdata (the acceptance edge) and move to WR (we=1) or RD (we=0).
REQ-021 SHALL ignore req whenever the state is not IDLE, with no queuing.
REQ-022 SHALL, when N exceeds DW/8, move from IDLE to FIN with no memory access and pulse err together with done; rdata is then unchanged.
REQ-023 SHALL use little-endian byte order: byte k is at address addr+k and maps to bits 8k+7:8k.
REQ-024 SHALL compute addresses modulo 2^AW, so addr+k wraps from all-ones to 0.
REQ-025 SHALL, in WR, drive one byte per cycle for k = 0..N-1 with mem_we=1, mem_addr=addr+k and mem_wdata=byte k, then go to FIN; a store therefore takes N+1 cycles after acceptance, done included.
REQ-026 SHALL, in RD, issue mem_addr=addr+k for k = 0..N-1 (one per cycle), with mem_we=0.
REQ-027 SHALL capture mem_rdata into byte slot k one cycle after that byte's address is issued.
REQ-028 SHALL use DRAIN (one cycle) to capture byte N-1, then go to FIN; a load therefore takes N+2 cycles after acceptance, done included.
REQ-029 SHALL, in FIN, pulse done for one cycle and return to IDLE; a new req is accepted in the following cycle.
REQ-030 SHALL update rdata on the edge entering FIN of a successful load: bytes N..DW/8-1 are 0x00 when sext=0, or replicate bit 8N-1 when sext=1.
REQ-031 SHALL hold rdata stable otherwise: through stores, rejected requests and idle cycles.
REQ-032 SHALL ignore sext for stores.
REQ-033 SHALL keep mem_we=0 in every state other than WR.
REQ-034 SHALL hold mem_addr and mem_wdata at their last values when not driving them.
REQ-035 SHALL let the sampled inputs change freely after acceptance without affecting the operation in flight.

Reset
REQ-036 SHALL, when rst is asserted, immediately and asynchronously force state=IDLE, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata=0.
REQ-037 SHALL treat reset during WR/RD/DRAIN as an abort: no further memory writes, no done pulse, and partially captured bytes discarded.
REQ-038 SHALL sample no req while rst is high; the first acceptance is possible on the first rising edge with rst low.

Verification
REQ-039 SHALL cover a store: DW=64, addr=0x0010, size=2, wdata=0x...A1B2C3D4 → writes 0xD4,0xC3,0xB2,0xA1 to 0x0010..0x0013 on 4 consecutive cycles; done 5 cycles after acceptance.
REQ-040 SHALL cover a sign-extended load: RAM 0x0020..0x0021 = 0x34,0x85, size=1, sext=1 → rdata=0xFFFF_FFFF_FFFF_8534 with done 4 cycles after acceptance; the same with sext=0 → 0x0000_0000_0000_8534.
REQ-041 SHALL cover address wrap: AW=16, addr=0xFFFE, size=2 load → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-042 SHALL cover rejection: DW=32, size=3 → err=1 and done=1 in the same cycle, mem_we never asserted, rdata unchanged.
REQ-043 SHALL cover busy/abort: req pulsed during an 8-byte store is ignored; rst asserted after the 3rd byte write → mem_we drops at once, exactly 3 bytes written, no done pulse, rdata=0.
